// File: rtl/product_accumulator_pkg.sv
// Shared types and defaults for the product accumulator: FSM states, default
// widths and a reference saturating add for the default widths.
package product_accumulator_pkg;

  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 18;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_ACC_W-1:0] sum;
    logic                 ovf;
  } sat_res_t;

  // Saturating unsigned add at the default widths; the carry out of the
  // widened sum is the overflow indication.
  function automatic sat_res_t sat_add(input logic [DEF_ACC_W-1:0]  acc,
                                       input logic [DEF_PROD_W-1:0] prod);
    logic [DEF_ACC_W:0] wide;
    sat_res_t           res;
    wide    = {1'b0, acc} + {{(DEF_ACC_W + 1 - DEF_PROD_W){1'b0}}, prod};
    res.ovf = wide[DEF_ACC_W];
    res.sum = res.ovf ? {DEF_ACC_W{1'b1}} : wide[DEF_ACC_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational unsigned add of a product into the accumulator, clamping to
// all ones and flagging overflow when the sum does not fit in ACC_W bits.
module product_accumulator_sat_adder
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W:0] wide_sum;

  assign wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign ovf_o    = wide_sum[ACC_W];
  assign sum_o    = ovf_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a programmable-length block of multiplier products into a
// saturating sum and presents it on a held valid/ready result port.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clear,
  input  logic [CNT_W-1:0]  block_len,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);

  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               out_take;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [ACC_W-1:0]   first_sum;

  assign accept    = in_valid & in_ready_q & ena;
  assign out_take  = out_valid_q & out_ready & ena;
  assign first_sum = {{(ACC_W - PROD_W){1'b0}}, in_data};

  product_accumulator_sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_adder (
    .acc_i  (acc_q),
    .prod_i (in_data),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;

    if (ena) begin
      if (clear) begin
        state_d     = IDLE;
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        overflow_d  = 1'b0;
        in_ready_d  = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            // First enabled edge after reset raises in_ready here.
            in_ready_d = 1'b1;
            if (accept) begin
              len_d      = block_len;
              acc_d      = first_sum;
              cnt_d      = CNT_ONE;
              overflow_d = 1'b0;
              if (block_len == '0) begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
                out_data_d  = first_sum;
                in_ready_d  = 1'b0;
              end else begin
                state_d = ACCUM;
              end
            end
          end
          ACCUM: begin
            if (accept) begin
              acc_d      = add_sum;
              cnt_d      = cnt_q + CNT_ONE;
              overflow_d = overflow_q | add_ovf;
              // cnt is one bit wider than len_q so the last count never wraps.
              if (cnt_q == {1'b0, len_q}) begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
                out_data_d  = add_sum;
                in_ready_d  = 1'b0;
              end
            end
          end
          HOLD: begin
            if (out_take) begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              acc_d       = '0;
              cnt_d       = '0;
              overflow_d  = 1'b0;
              in_ready_d  = 1'b1;
            end
          end
          default: begin
            state_d    = IDLE;
            acc_d      = '0;
            cnt_d      = '0;
            in_ready_d = 1'b1;
          end
        endcase
      end
    end

    busy_d = ena ? (state_d != IDLE) : busy_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: hand-computed block sums, saturation,
// stalls, clear, enable gating and asynchronous reset.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        clear;
  logic [3:0]  block_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [17:0] out_data;
  logic        out_ready;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  product_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clear     (clear),
    .block_len (block_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and complete its handshake (bounded wait for in_ready).
  task automatic feed(input logic [15:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL feed_ready: in_ready=%b required 1 (data %0d)", in_ready, d);
      failures++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL drain: out_valid=%b overflow=%b in_ready=%b busy=%b required 0 0 1 0",
               out_valid, overflow, in_ready, busy);
      failures++;
    end
    $display("drain done: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; block_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out_data, overflow, busy} !== 22'd0) begin
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%0d overflow=%b busy=%b required all 0",
               in_ready, out_valid, out_data, overflow, busy);
      failures++;
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_release_ready: in_ready=%b required 0 before first edge", in_ready);
      failures++;
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_first_edge: in_ready=%b busy=%b required 1 0", in_ready, busy);
      failures++;
    end
    $display("reset: in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_basic_block();
    block_len = 4'd3;
    for (int i = 0; i < 3; i++) feed(16'd150);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL basic_partial: out_valid=%b busy=%b in_ready=%b required 0 1 1",
               out_valid, busy, in_ready);
      failures++;
    end
    feed(16'd150);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd600 || overflow !== 1'b0 ||
        busy !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL basic_result: out_valid=%b out_data=%0d overflow=%b busy=%b in_ready=%b required 1 600 0 1 0",
               out_valid, out_data, overflow, busy, in_ready);
      failures++;
    end
    $display("basic block: out_data=%0d overflow=%b", out_data, overflow);
    drain();
  endtask

  task automatic test_single_sample();
    block_len = 4'd0;
    feed(16'd65535);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd65535 || in_ready !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL single_result: out_valid=%b out_data=%0d in_ready=%b busy=%b required 1 65535 0 1",
               out_valid, out_data, in_ready, busy);
      failures++;
    end
    $display("single sample: out_data=%0d", out_data);
    drain();
  endtask

  task automatic test_saturation();
    block_len = 4'd4;
    for (int i = 0; i < 4; i++) feed(16'd65535);
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL sat_before: overflow=%b out_valid=%b required 0 0 after 262140",
               overflow, out_valid);
      failures++;
    end
    feed(16'd65535);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd262143 || overflow !== 1'b1) begin
      $display("FAIL sat_result: out_valid=%b out_data=%0d overflow=%b required 1 262143 1",
               out_valid, out_data, overflow);
      failures++;
    end
    $display("saturation: out_data=%0d overflow=%b", out_data, overflow);
    drain();
  endtask

  task automatic test_full_length();
    block_len = 4'd15;
    for (int i = 0; i < 15; i++) feed(16'd1000);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL full_partial: out_valid=%b busy=%b required 0 1 after 15 samples",
               out_valid, busy);
      failures++;
    end
    feed(16'd1000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd16000) begin
      $display("FAIL full_result: out_valid=%b out_data=%0d required 1 16000", out_valid, out_data);
      failures++;
    end
    $display("full length: out_data=%0d", out_data);
    drain();
  endtask

  task automatic test_hold_stall();
    block_len = 4'd0;
    feed(16'd1234);
    in_valid = 1'b1;
    in_data  = 16'd99;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 18'd1234 || in_ready !== 1'b0) begin
        $display("FAIL stall_cycle%0d: out_valid=%b out_data=%0d in_ready=%b required 1 1234 0",
                 i, out_valid, out_data, in_ready);
        failures++;
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL stall_release: out_valid=%b busy=%b in_ready=%b required 0 0 1",
               out_valid, busy, in_ready);
      failures++;
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd99) begin
      $display("FAIL stall_next: out_valid=%b out_data=%0d required 1 99", out_valid, out_data);
      failures++;
    end
    $display("hold stall: next result=%0d", out_data);
    drain();
  endtask

  task automatic test_clear();
    block_len = 4'd3;
    feed(16'd100);
    feed(16'd100);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd55;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL clear_state: busy=%b in_ready=%b out_valid=%b overflow=%b required 0 1 0 0",
               busy, in_ready, out_valid, overflow);
      failures++;
    end
    block_len = 4'd1;
    feed(16'd7);
    feed(16'd8);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd15) begin
      $display("FAIL clear_result: out_valid=%b out_data=%0d required 1 15", out_valid, out_data);
      failures++;
    end
    $display("clear: new block sum=%0d", out_data);
    drain();
  endtask

  task automatic test_len_sampled();
    block_len = 4'd1;
    feed(16'd5);
    block_len = 4'd7;
    feed(16'd6);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd11) begin
      $display("FAIL len_sampled: out_valid=%b out_data=%0d required 1 11", out_valid, out_data);
      failures++;
    end
    $display("len sampled: out_data=%0d", out_data);
    drain();
  endtask

  task automatic test_enable();
    block_len = 4'd1;
    feed(16'd10);
    ena      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd20;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL ena_freeze: out_valid=%b busy=%b in_ready=%b required 0 1 1",
               out_valid, busy, in_ready);
      failures++;
    end
    ena = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd30) begin
      $display("FAIL ena_resume: out_valid=%b out_data=%0d required 1 30", out_valid, out_data);
      failures++;
    end
    ena       = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd30) begin
      $display("FAIL ena_out_hold: out_valid=%b out_data=%0d required 1 30", out_valid, out_data);
      failures++;
    end
    ena       = 1'b1;
    out_ready = 1'b0;
    $display("enable gating: out_data=%0d", out_data);
    drain();
  endtask

  task automatic test_async_reset();
    block_len = 4'd3;
    feed(16'd1);
    feed(16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, in_ready, busy, overflow} !== 22'd0) begin
      $display("FAIL async_reset: out_valid=%b out_data=%0d in_ready=%b busy=%b overflow=%b required all 0",
               out_valid, out_data, in_ready, busy, overflow);
      failures++;
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL async_release: in_ready=%b required 0", in_ready);
      failures++;
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL async_first_edge: in_ready=%b busy=%b required 1 0", in_ready, busy);
      failures++;
    end
    block_len = 4'd0;
    feed(16'd42);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd42) begin
      $display("FAIL async_restart: out_valid=%b out_data=%0d required 1 42", out_valid, out_data);
      failures++;
    end
    $display("async reset: restart result=%0d", out_data);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_single_sample();
    test_saturation();
    test_full_length();
    test_hold_stall();
    test_clear();
    test_len_sampled();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
